// File: rtl/cache_line_adapter.sv
// rtl/cache_line_adapter.sv - cache line <-> 4-beat burst memory adapter
// Collects read bursts into a line on fills and streams a latched line out on writebacks.
module cache_line_adapter #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  ufp_addr,
  input  logic                   ufp_read,
  input  logic                   ufp_write,
  input  logic [LINE_WIDTH-1:0]  ufp_wdata,
  output logic [LINE_WIDTH-1:0]  ufp_rdata,
  output logic                   ufp_resp,
  output logic [ADDR_WIDTH-1:0]  bmem_addr,
  output logic                   bmem_read,
  output logic                   bmem_write,
  output logic [BURST_WIDTH-1:0] bmem_wdata,
  input  logic                   bmem_ready,
  input  logic [BURST_WIDTH-1:0] bmem_rdata,
  input  logic                   bmem_rvalid
);

  localparam int BURSTS = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W  = $clog2(BURSTS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURSTS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic [LINE_WIDTH-1:0]   rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    ufp_resp   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ufp_write) begin
          state_d = WR_DATA;
        end else if (ufp_read) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
        if (bmem_ready) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        bmem_addr = addr_q;
        if (bmem_rvalid && cnt_q == LAST_BEAT) begin
          state_d = DONE;
        end
      end
      WR_DATA: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = line_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH];
        if (bmem_ready && cnt_q == LAST_BEAT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ufp_resp = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // line_q doubles as fill assembly buffer and writeback source; rdata_q only moves on fill completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (ufp_write) begin
            addr_q <= ufp_addr & ALIGN_MASK;
            line_q <= ufp_wdata;
          end else if (ufp_read) begin
            addr_q <= ufp_addr & ALIGN_MASK;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            cnt_q <= '0;
          end
        end
        RD_DATA: begin
          if (bmem_rvalid) begin
            line_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] <= bmem_rdata;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
              rdata_q <= {bmem_rdata, line_q[LINE_WIDTH-BURST_WIDTH-1:0]};
            end
          end
        end
        WR_DATA: begin
          if (bmem_ready) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ufp_rdata = rdata_q;

endmodule
